// File: rtl/if_id_ctrl.sv
// if_id_ctrl: IF/ID controller with 2-entry skid queue, load-use bubble and flush squash.
// Define IF_ID_PERF_CNT_EN to add stall/flush performance counter ports.
module if_id_ctrl #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic            id_fire,
  output logic            id_bubble,
  input  logic            ex_ready,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            flush
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);
  logic [1:0]      occ_q, occ_d;
  logic [31:0]     instr0_q, instr0_d, instr1_q, instr1_d;
  logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [6:0]      op;
  logic            rs1_used, rs2_used, hazard, push, ld0, ld1;
  assign op        = instr0_q[6:0];
  assign rs1_used  = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  assign rs2_used  = op == 7'b0100011 || op == 7'b1100011 || op == 7'b0110011;
  assign id_valid  = occ_q != 2'd0;
  assign if_ready  = occ_q != 2'd2;
  assign id_instr  = instr0_q;
  assign id_pc     = pc0_q;
  assign hazard    = id_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
                     ((rs1_used && instr0_q[19:15] == ex_rd) || (rs2_used && instr0_q[24:20] == ex_rd));
  assign id_fire   = id_valid && ex_ready && !hazard && !flush;
  assign id_bubble = hazard && ex_ready && !flush;
  assign push      = if_valid && if_ready && !flush;
  // New word lands in the head when the queue is empty or the head leaves this cycle
  always_comb begin
    ld0      = push && (id_fire || occ_q == 2'd0);
    ld1      = push && !id_fire && occ_q == 2'd1;
    occ_d    = flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, id_fire};
    instr0_d = ld0 ? if_instr : id_fire ? instr1_q : instr0_q;
    pc0_d    = ld0 ? if_pc : id_fire ? pc1_q : pc0_q;
    instr1_d = ld1 ? if_instr : instr1_q;
    pc1_d    = ld1 ? if_pc : pc1_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q    <= 2'd0;
      instr0_q <= 32'h0000_0013;
      pc0_q    <= '0;
      instr1_q <= 32'h0000_0013;
      pc1_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      instr0_q <= instr0_d;
      pc0_q    <= pc0_d;
      instr1_q <= instr1_d;
      pc1_q    <= pc1_d;
    end
  end
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, id_bubble};
      flush_cnt_q <= flush_cnt_q + {31'd0, flush && occ_q != 2'd0};
    end
  end
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule
